// File: rtl/cs_stream_seq.sv
// cs_stream_seq: handshake sequencer for the 9-tap comparator/selector datapath.
// Keeps a circular window of the last WIN samples with a running sum. Once the
// window is full, each accepted sample triggers a serial scan for the largest
// entry not above floor(avg). The result Y = floor((sum + WIN*best) / 8) is then
// offered on a valid/ready output.
module cs_stream_seq #(
    parameter int WIN = 9,
    parameter int DW  = 8,
    parameter int SW  = 12,
    parameter int OW  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] X,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] Y,
    output logic          busy
);

    localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int FW = $clog2(WIN + 1);
    localparam logic [PW-1:0] LAST  = PW'(WIN - 1);
    localparam logic [FW-1:0] FULL  = FW'(WIN);
    localparam logic [FW-1:0] ALMOST = FW'(WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AVG  = 3'd1,
        S_SCAN = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t        state_q;
    logic [DW-1:0] win_q [WIN];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] idx_q;
    logic [FW-1:0] fill_q;
    logic [SW-1:0] sum_q;
    logic [DW-1:0] avg_q;
    logic [DW-1:0] best_q;
    logic [OW-1:0] y_q;

    logic [SW-1:0] sum_d;
    logic [DW-1:0] avg_d;
    logic [OW-1:0] y_d;

    // Result = floor((sum + WIN*best) / 8); one extra bit holds the pre-shift total.
    function automatic logic [OW-1:0] calc_y(input logic [SW-1:0] s, input logic [DW-1:0] b);
        logic [SW:0] t;
        t = {1'b0, s} + (SW+1)'(WIN) * {{(SW+1-DW){1'b0}}, b};
        return OW'(t >> 3);
    endfunction

    // Next-value arithmetic: sliding sum (old entry leaves, new one enters), mean, result.
    always_comb begin
        sum_d = sum_q - SW'(win_q[wptr_q]) + SW'(X);
        avg_d = DW'(sum_q / SW'(WIN));
        y_d   = calc_y(sum_q, best_q);
    end

    // Sequencer: window update in IDLE, then AVG -> SCAN -> CALC -> OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            wptr_q  <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            best_q  <= '0;
            y_q     <= '0;
        end else if (clr) begin
            // Clear wins over any handshake on the same edge.
            state_q <= S_IDLE;
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            wptr_q  <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            best_q  <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sum_q         <= sum_d;
                        win_q[wptr_q] <= X;
                        wptr_q        <= (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
                        if (fill_q != FULL) fill_q <= fill_q + FW'(1);
                        // Still warming up until this sample completes the window.
                        if (fill_q >= ALMOST) state_q <= S_AVG;
                    end
                end
                S_AVG: begin
                    avg_q   <= avg_d;
                    best_q  <= '0;
                    idx_q   <= '0;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (win_q[idx_q] <= avg_q && win_q[idx_q] > best_q) best_q <= win_q[idx_q];
                    if (idx_q == LAST) begin
                        state_q <= S_CALC;
                    end else begin
                        idx_q <= idx_q + PW'(1);
                    end
                end
                S_CALC: begin
                    y_q     <= y_d;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign Y         = y_q;

endmodule

// File: tb/tb_cs_stream_seq.sv
// Self-checking bench for cs_stream_seq: directed vector table, hand-written
// backpressure and abort sequences, then randomized traffic against a
// window-of-last-samples reference model.
module tb_cs_stream_seq;

    localparam int WIN = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] X;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] Y;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int mq[$];

    typedef struct {
        bit clr_first;
        int x;
        int y;   // -1: no result expected, -2: take the reference model's value
    } vec_t;
    vec_t tbl[$];

    cs_stream_seq #(.WIN(WIN), .DW(8), .SW(12), .OW(10)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: Y over the last WIN accepted samples, straight from the definition.
    function automatic int model_y();
        int s, avg, best;
        s = 0;
        foreach (mq[i]) s += mq[i];
        avg = s / WIN;
        best = 0;
        foreach (mq[i]) if (mq[i] <= avg && mq[i] > best) best = mq[i];
        return (s + WIN * best) / 8;
    endfunction

    task automatic do_clr(input string name);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        mq.delete();
        chk({name, "_rdy"}, int'(in_ready), 1);
        chk({name, "_ov"}, int'(out_valid), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic send(input int x, input int exp_y, input int bp, input string name);
        int cnt;
        int e;
        bit no_out;
        out_ready = (bp == 0);
        cnt = 0;
        while (!in_ready && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) begin
            chk({name, "_rdy_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1;
        X = x[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        mq.push_back(x);
        if (mq.size() > WIN) void'(mq.pop_front());
        no_out = (exp_y == -1) || (exp_y == -2 && mq.size() < WIN);
        if (no_out) begin
            chk({name, "_warm_ov"}, int'(out_valid), 0);
            chk({name, "_warm_rdy"}, int'(in_ready), 1);
            out_ready = 1'b1;
            return;
        end
        e = (exp_y >= 0) ? exp_y : model_y();
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({name, "_lat"}, cnt, WIN + 2);
        chk({name, "_y"}, int'(Y), e);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            X = 8'hAA;
            chk({name, "_bp_y"}, int'(Y), e);
            chk({name, "_bp_rdy"}, int'(in_ready), 0);
            chk({name, "_bp_ov"}, int'(out_valid), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_ov_drop"}, int'(out_valid), 0);
    endtask

    task automatic abort_run(input bit use_reset, input string name);
        int cnt;
        bit seen;
        cnt = 0;
        while (!in_ready && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b1;
        X = 8'($urandom_range(0, 255));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk({name, "_busy_scan"}, int'(busy), 1);
        if (use_reset) reset = 1'b0;
        else clr = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        clr = 1'b0;
        mq.delete();
        chk({name, "_ov"}, int'(out_valid), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_rdy"}, int'(in_ready), 1);
        chk({name, "_y0"}, int'(Y), 0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk({name, "_no_out"}, int'(seen), 0);
        for (int i = 0; i < WIN - 1; i++) send($urandom_range(0, 255), -1, 0, {name, "_refill"});
        send($urandom_range(0, 255), -2, 0, {name, "_first"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0; X = '0; out_ready = 1'b1;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            clr       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            X         = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("rst_rdy", int'(in_ready), 1);
            chk("rst_ov", int'(out_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_y", int'(Y), 0);
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: warm-up, slide, extremes.
        for (int i = 1; i <= 8; i++) tbl.push_back('{1'b0, i, -1});
        tbl.push_back('{1'b0, 9, 11});
        tbl.push_back('{1'b0, 10, 13});
        tbl.push_back('{1'b0, 0, 12});
        for (int i = 0; i < 8; i++) tbl.push_back('{(i == 0), 255, -1});
        tbl.push_back('{1'b0, 255, 573});
        for (int i = 0; i < 8; i++) tbl.push_back('{(i == 0), 0, -1});
        tbl.push_back('{1'b0, 0, 0});

        foreach (tbl[i]) begin
            if (tbl[i].clr_first) do_clr($sformatf("vec%0d_clr", i));
            send(tbl[i].x, tbl[i].y, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: result held, input blocked, offered sample not consumed.
        send(200, -2, 5, "bp1");
        send(17, -2, 0, "bp_after");

        // Abort mid-scan by clear, then by reset.
        abort_run(1'b0, "abort_clr");
        abort_run(1'b1, "abort_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int x;
            if ($urandom_range(0, 11) == 0) do_clr($sformatf("rnd%0d_clr", i));
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            send(x, -2, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < WIN; i++) send($urandom_range(0, 255), -2, 0, $sformatf("tail%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
